// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mem_pkg : shared types and default widths for the memory port   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package riscv_mem_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : enable-driven up counter that sticks at all-ones        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : round-robin share of one memory port between I$ and D$  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  i_wait_cycles,
    output logic [CNT_W-1:0]  d_wait_cycles
);

    state_t            state_q,      state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              write_q,      write_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              i_ready_q,    i_ready_d;
    logic              d_ready_q,    d_ready_d;

    logic w_d_req;
    logic w_serving;

    assign w_d_req   = d_read | d_write;
    assign w_serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, D wins unless it was the last one served.
                if (w_d_req && (!i_read || (last_grant_q == GRANT_I))) begin
                    state_d = SERVE_D;
                    write_d = d_write;
                    addr_d  = d_addr;
                    if (d_write) begin
                        wdata_d = d_wdata;
                    end
                end else if (i_read) begin
                    state_d = SERVE_I;
                    write_d = 1'b0;
                    addr_d  = i_addr;
                end
            end
            SERVE_I: begin
                if (mem_ready) begin
                    i_rdata_d    = mem_rdata;
                    i_ready_d    = 1'b1;
                    last_grant_d = GRANT_I;
                    state_d      = RELEASE;
                end
            end
            SERVE_D: begin
                if (mem_ready) begin
                    if (!write_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d    = 1'b1;
                    last_grant_d = GRANT_D;
                    state_d      = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign mem_read  = w_serving && !write_q;
    assign mem_write = w_serving &&  write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

    logic w_i_wait_en;
    logic w_d_wait_en;

    assign w_i_wait_en = i_read  && !i_ready_q;
    assign w_d_wait_en = w_d_req && !d_ready_q;

    sat_counter #(.CNT_W(CNT_W)) u_i_wait (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (w_i_wait_en),
        .cnt_o (i_wait_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_d_wait (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (w_d_wait_en),
        .cnt_o (d_wait_cycles)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed checks of arbitration, handshake, counters  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  i_wait_cycles;
    logic [CNT_W-1:0]  d_wait_cycles;

    int total = 0;
    int bad   = 0;

    localparam logic [DATA_W-1:0] C_BEEF = 128'hDEADBEEF;
    localparam logic [DATA_W-1:0] C_A    = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    localparam logic [DATA_W-1:0] C_B    = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    localparam logic [DATA_W-1:0] C_C    = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    localparam logic [DATA_W-1:0] C_WD   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_read        (i_read),
        .i_addr        (i_addr),
        .i_rdata       (i_rdata),
        .i_ready       (i_ready),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_ready       (d_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .i_wait_cycles (i_wait_cycles),
        .d_wait_cycles (d_wait_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_i_ready", i_ready, 1'b0);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_i_wait", i_wait_cycles, '0);
        rst = 1'b1;
        tick();

        // single I read, memory answers on the third strobe cycle
        i_read = 1'b1; i_addr = 28'h0000010;
        tick();
        chk("i1_mem_read_c1", mem_read, 1'b1);
        chk("i1_mem_addr", mem_addr, 28'h0000010);
        chk("i1_mem_write", mem_write, 1'b0);
        tick();
        chk("i1_mem_read_c2", mem_read, 1'b1);
        tick();
        chk("i1_mem_read_c3", mem_read, 1'b1);
        mem_ready = 1'b1; mem_rdata = C_BEEF;
        tick();
        chk("i1_i_ready", i_ready, 1'b1);
        chk("i1_i_rdata", i_rdata, C_BEEF);
        chk("i1_mem_read_off", mem_read, 1'b0);
        chk("i1_i_wait", i_wait_cycles, 16'd4);
        mem_ready = 1'b0; i_read = 1'b0;
        tick();
        chk("i1_i_ready_pulse", i_ready, 1'b0);
        chk("i1_i_wait_hold", i_wait_cycles, 16'd4);

        // fresh reset, then simultaneous requests: D wins first tie
        rst = 1'b0;
        #1;
        chk("rst2_i_wait", i_wait_cycles, '0);
        chk("rst2_i_rdata", i_rdata, '0);
        rst = 1'b1;
        tick();
        i_read = 1'b1; i_addr = 28'h0000100;
        d_read = 1'b1; d_addr = 28'h0000200;
        tick();
        chk("tie1_addr_d", mem_addr, 28'h0000200);
        chk("tie1_mem_read", mem_read, 1'b1);
        mem_ready = 1'b1; mem_rdata = C_A;
        tick();
        chk("tie1_d_ready", d_ready, 1'b1);
        chk("tie1_d_rdata", d_rdata, C_A);
        chk("tie1_i_ready", i_ready, 1'b0);
        chk("tie1_d_wait", d_wait_cycles, 16'd2);
        d_read = 1'b0; mem_ready = 1'b0;
        tick();
        chk("tie1_release_idle", mem_read, 1'b0);
        // D requests again alongside the still-pending I: I now wins
        d_read = 1'b1; d_addr = 28'h0000300;
        tick();
        chk("tie2_addr_i", mem_addr, 28'h0000100);
        mem_ready = 1'b1; mem_rdata = C_B;
        tick();
        chk("tie2_i_ready", i_ready, 1'b1);
        chk("tie2_i_rdata", i_rdata, C_B);
        chk("tie2_d_rdata_kept", d_rdata, C_A);
        i_read = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        chk("tie2_addr_d", mem_addr, 28'h0000300);
        chk("tie2_d_mem_read", mem_read, 1'b1);
        mem_ready = 1'b1; mem_rdata = C_C;
        tick();
        chk("tie2_d_rdata", d_rdata, C_C);
        d_read = 1'b0; mem_ready = 1'b0;
        tick();

        // write-back with d_read also high: served as write
        d_write = 1'b1; d_read = 1'b1; d_addr = 28'h0000020; d_wdata = C_WD;
        tick();
        chk("wr_mem_write", mem_write, 1'b1);
        chk("wr_mem_read", mem_read, 1'b0);
        chk("wr_mem_wdata", mem_wdata, C_WD);
        chk("wr_mem_addr", mem_addr, 28'h0000020);
        mem_ready = 1'b1; mem_rdata = '1;
        tick();
        chk("wr_d_ready", d_ready, 1'b1);
        chk("wr_d_rdata_unchanged", d_rdata, C_C);
        chk("wr_strobe_off", mem_write, 1'b0);
        d_write = 1'b0; d_read = 1'b0; mem_ready = 1'b0;
        tick();

        // request held through RELEASE is served exactly once
        i_read = 1'b1; i_addr = 28'h0000040;
        tick();
        mem_ready = 1'b1; mem_rdata = C_A;
        tick();
        chk("hold_i_ready", i_ready, 1'b1);
        mem_ready = 1'b0;
        tick();
        chk("hold_no_double", i_ready, 1'b0);
        chk("hold_no_strobe", mem_read, 1'b0);
        i_read = 1'b0;
        tick();
        chk("hold_no_reserve", mem_read, 1'b0);

        // reset while D waits on memory
        d_read = 1'b1; d_addr = 28'h0000050;
        tick();
        chk("rmid_mem_read", mem_read, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rmid_mem_read_off", mem_read, 1'b0);
        chk("rmid_mem_addr", mem_addr, '0);
        chk("rmid_d_rdata", d_rdata, '0);
        chk("rmid_i_rdata", i_rdata, '0);
        chk("rmid_d_wait", d_wait_cycles, '0);
        d_read = 1'b0;
        tick();
        rst = 1'b1;
        mem_ready = 1'b1; mem_rdata = C_B;
        tick();
        chk("rmid_late_ready", d_ready, 1'b0);
        chk("rmid_late_rdata", d_rdata, '0);
        chk("rmid_idle", mem_read, 1'b0);
        mem_ready = 1'b0;
        tick();

        // saturation of the I wait counter
        rst = 1'b0;
        #1;
        rst = 1'b1;
        i_read = 1'b1; i_addr = 28'h0000060;
        repeat (65534) tick();
        chk("sat_near", i_wait_cycles, 16'hFFFE);
        repeat (10) tick();
        chk("sat_top", i_wait_cycles, 16'hFFFF);
        chk("sat_still_read", mem_read, 1'b1);
        chk("sat_d_wait", d_wait_cycles, 16'h0000);
        i_read = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
